// File: rtl/cnt_pair_checker.sv
// -----------------------------------------------------------------------------
// cnt_pair_checker
//
// Watches two 4-bit free-running counter streams. Each stream must advance by
// exactly one (mod 16) from its previous valid sample. After LOCK_CNT
// consecutive good samples the checker declares lock. A bad sample while
// locked raises a one-cycle error pulse, sets a sticky flag and bumps a
// saturating error counter, then drops back to SYNC to re-acquire lock.
//
// Optional feature (compile-time macro CNT_CHK_MISMATCH_EN):
//   when defined, a sample is also bad if i_cnt1 != i_cnt2. When undefined,
//   the streams are checked independently, so a fixed offset is allowed.
//
// Parameters:
//   LOCK_CNT      consecutive good samples needed to lock (1..15)
//   ERR_W         width of the error counter
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_valid       sample strobe for i_cnt1/i_cnt2
//   i_cnt1        first counter stream
//   i_cnt2        second counter stream
//   i_clr         synchronous clear of o_err_sticky and o_err_cnt
//   o_state       0=IDLE, 1=SYNC, 2=LOCKED
//   o_locked      high while in LOCKED
//   o_err         one-cycle error pulse
//   o_err_sticky  latched error flag
//   o_err_cnt     saturating error count
// -----------------------------------------------------------------------------
module cnt_pair_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [3:0]       i_cnt1,
    input  logic [3:0]       i_cnt2,
    input  logic             i_clr,
    output logic [1:0]       o_state,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_err_sticky,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } state_e;

    localparam logic [3:0] LockTarget = 4'(LOCK_CNT);

    state_e           state_q;
    logic [3:0]       run_q;
    logic [3:0]       prev1_q;
    logic [3:0]       prev2_q;
    logic             locked_q;
    logic             err_q;
    logic             sticky_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic seq_good;
    logic good;
    logic run_hit;
    logic lock_err;

    always_comb begin
        // 4-bit compare makes 4'hF -> 4'h0 a legal step.
        seq_good = (i_cnt1 == prev1_q + 4'd1) && (i_cnt2 == prev2_q + 4'd1);
`ifdef CNT_CHK_MISMATCH_EN
        good     = seq_good && (i_cnt1 == i_cnt2);
`else
        good     = seq_good;
`endif
        run_hit  = (run_q + 4'd1) == LockTarget;
        // Only a bad sample seen while locked counts as an error.
        lock_err = i_valid && (state_q == StLocked) && !good;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            run_q     <= 4'd0;
            prev1_q   <= 4'd0;
            prev2_q   <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= lock_err;

            if (i_valid) begin
                // Every valid sample, good or bad, becomes the new reference.
                prev1_q <= i_cnt1;
                prev2_q <= i_cnt2;

                unique case (state_q)
                    StIdle: begin
                        state_q  <= StSync;
                        run_q    <= 4'd0;
                        locked_q <= 1'b0;
                    end
                    StSync: begin
                        if (good) begin
                            run_q <= run_q + 4'd1;
                            if (run_hit) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run_q <= 4'd0;
                        end
                    end
                    StLocked: begin
                        if (!good) begin
                            state_q  <= StSync;
                            locked_q <= 1'b0;
                            run_q    <= 4'd0;
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        locked_q <= 1'b0;
                        run_q    <= 4'd0;
                    end
                endcase
            end

            // Clear wins over a coincident error; the pulse above still fires.
            if (i_clr) begin
                sticky_q  <= 1'b0;
                err_cnt_q <= '0;
            end else if (lock_err) begin
                sticky_q <= 1'b1;
                if (err_cnt_q != {ERR_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
            end
        end
    end

    assign o_state      = state_q;
    assign o_locked     = locked_q;
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cnt_pair_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_pair_checker
//
// Directed bench for cnt_pair_checker. Two instances share the stimulus: one
// with default parameters and one with ERR_W=2 for the saturation case.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_cnt_pair_checker;

`ifdef CNT_CHK_MISMATCH_EN
    localparam bit MismatchEn = 1'b1;
`else
    localparam bit MismatchEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic       clr;

    logic [1:0] state_a;
    logic       locked_a;
    logic       err_a;
    logic       sticky_a;
    logic [7:0] err_cnt_a;

    logic [1:0] state_b;
    logic       locked_b;
    logic       err_b;
    logic       sticky_b;
    logic [1:0] err_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cnt_pair_checker #(
        .LOCK_CNT(4),
        .ERR_W   (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_cnt1      (cnt1),
        .i_cnt2      (cnt2),
        .i_clr       (clr),
        .o_state     (state_a),
        .o_locked    (locked_a),
        .o_err       (err_a),
        .o_err_sticky(sticky_a),
        .o_err_cnt   (err_cnt_a)
    );

    cnt_pair_checker #(
        .LOCK_CNT(4),
        .ERR_W   (2)
    ) dut_w2 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_cnt1      (cnt1),
        .i_cnt2      (cnt2),
        .i_clr       (clr),
        .o_state     (state_b),
        .o_locked    (locked_b),
        .o_err       (err_b),
        .o_err_sticky(sticky_b),
        .o_err_cnt   (err_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic c);
        @(negedge clk);
        valid = v;
        cnt1  = a;
        cnt2  = b;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] v;
    logic [1:0] exp_state [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        cnt1  = 4'd0;
        cnt2  = 4'd0;
        clr   = 1'b0;

        // Reset values.
        @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state_a), 32'd0);
        check_eq("rst_locked", 32'(locked_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_sticky", 32'(sticky_a), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Acquire lock on 0..5; an idle cycle with junk data sits after sample 2.
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 4'(i), 4'(i), 1'b0);
            check_eq($sformatf("acq_state_%0d", i), 32'(state_a), 32'(exp_state[i]));
            check_eq($sformatf("acq_err_%0d", i), 32'(err_a), 32'd0);
            if (i == 2) begin
                send(1'b0, 4'd9, 4'd9, 1'b0);
                check_eq("idle_state", 32'(state_a), 32'd1);
            end
        end
        check_eq("acq_locked", 32'(locked_a), 32'd1);

        // Run through the 15 -> 0 wrap while locked.
        for (int i = 6; i < 18; i++) begin
            send(1'b1, 4'(i), 4'(i), 1'b0);
        end
        check_eq("wrap_state", 32'(state_a), 32'd2);
        check_eq("wrap_err_cnt", 32'(err_cnt_a), 32'd0);
        check_eq("wrap_sticky", 32'(sticky_a), 32'd0);

        // cnt1 jumps 6 -> 9 while locked.
        for (int i = 2; i < 7; i++) begin
            send(1'b1, 4'(i), 4'(i), 1'b0);
        end
        send(1'b1, 4'd9, 4'd7, 1'b0);
        check_eq("jump_err", 32'(err_a), 32'd1);
        check_eq("jump_sticky", 32'(sticky_a), 32'd1);
        check_eq("jump_err_cnt", 32'(err_cnt_a), 32'd1);
        check_eq("jump_state", 32'(state_a), 32'd1);
        check_eq("jump_locked", 32'(locked_a), 32'd0);
        send(1'b0, 4'd9, 4'd7, 1'b0);
        check_eq("jump_err_pulse", 32'(err_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'(10 + i), 4'(8 + i), 1'b0);
        end
        check_eq("relock_state", 32'(state_a), MismatchEn ? 32'd1 : 32'd2);
        check_eq("relock_err_cnt", 32'(err_cnt_a), 32'd1);

        // Fixed-offset streams: legal unless the mismatch check is built in.
        sync_reset();
        for (int i = 2; i < 7; i++) begin
            send(1'b1, 4'(i), 4'(i + 1), 1'b0);
        end
        send(1'b1, 4'd7, 4'd8, 1'b0);
        check_eq("offset_err", 32'(err_a), 32'd0);
        check_eq("offset_state", 32'(state_a), MismatchEn ? 32'd1 : 32'd2);
        check_eq("offset_err_cnt", 32'(err_cnt_a), 32'd0);

        // Repeated lock/error cycles; ERR_W=2 instance saturates at 3.
        sync_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 4'(i), 4'(i), 1'b0);
        end
        check_eq("sat_pre_state", 32'(state_a), 32'd2);
        v = 4'd4;
        for (int k = 1; k <= 5; k++) begin
            v = v + 4'd3;
            send(1'b1, v, v, 1'b0);
            check_eq($sformatf("sat_err_%0d", k), 32'(err_a), 32'd1);
            check_eq($sformatf("sat_cnt8_%0d", k), 32'(err_cnt_a), 32'(k));
            check_eq($sformatf("sat_cnt2_%0d", k), 32'(err_cnt_b), (k > 3) ? 32'd3 : 32'(k));
            for (int j = 0; j < 4; j++) begin
                v = v + 4'd1;
                send(1'b1, v, v, 1'b0);
            end
            check_eq($sformatf("sat_relock_%0d", k), 32'(state_b), 32'd2);
        end

        // Clear coincident with an error.
        v = v + 4'd3;
        send(1'b1, v, v, 1'b1);
        check_eq("clr_err", 32'(err_b), 32'd1);
        check_eq("clr_cnt2", 32'(err_cnt_b), 32'd0);
        check_eq("clr_sticky2", 32'(sticky_b), 32'd0);
        check_eq("clr_cnt8", 32'(err_cnt_a), 32'd0);
        check_eq("clr_state", 32'(state_a), 32'd1);
        send(1'b0, v, v, 1'b0);
        check_eq("clr_err_pulse", 32'(err_a), 32'd0);

        // Relock, take one error, relock again, then reset between edges.
        for (int j = 0; j < 4; j++) begin
            v = v + 4'd1;
            send(1'b1, v, v, 1'b0);
        end
        v = v + 4'd5;
        send(1'b1, v, v, 1'b0);
        for (int j = 0; j < 4; j++) begin
            v = v + 4'd1;
            send(1'b1, v, v, 1'b0);
        end
        check_eq("pre_arst_state", 32'(state_a), 32'd2);
        check_eq("pre_arst_err_cnt", 32'(err_cnt_a), 32'd1);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", 32'(state_a), 32'd0);
        check_eq("arst_locked", 32'(locked_a), 32'd0);
        check_eq("arst_sticky", 32'(sticky_a), 32'd0);
        check_eq("arst_err_cnt", 32'(err_cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 4'd5, 4'd5, 1'b0);
        check_eq("post_arst_state", 32'(state_a), 32'd1);
        check_eq("post_arst_err", 32'(err_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
